// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiply/divide unit.
// The master drives an M-op request; the slave returns stall, done and result.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      ALUSel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, ALUSel, op_a, op_b, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, ALUSel, op_a, op_b, flush,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: single-cycle (or 2-stage) multiply, radix-2 restoring divide.
// Optional feature: define MULDIV_SEQ_PIPE_MUL_EN to add a registered product stage to multiplies.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [4:0]      op_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic [XLEN-1:0] result_reg;

  // ---------------- request decode ----------------
  logic in_mul, in_div, in_m, in_rem, in_sdiv, in_sa, in_sb;

  always_comb begin
    in_mul  = (bus.ALUSel == OP_MUL)  || (bus.ALUSel == OP_MULH) ||
              (bus.ALUSel == OP_MULHSU) || (bus.ALUSel == OP_MULHU);
    in_div  = (bus.ALUSel == OP_DIV)  || (bus.ALUSel == OP_DIVU) ||
              (bus.ALUSel == OP_REM)  || (bus.ALUSel == OP_REMU);
    in_m    = in_mul || in_div;
    in_rem  = (bus.ALUSel == OP_REM)  || (bus.ALUSel == OP_REMU);
    in_sdiv = (bus.ALUSel == OP_DIV)  || (bus.ALUSel == OP_REM);
    in_sa   = (bus.ALUSel == OP_MULH) || (bus.ALUSel == OP_MULHSU);
    in_sb   = (bus.ALUSel == OP_MULH);
  end

  logic accept;
  assign accept = (state_reg == S_IDLE) && bus.start && !bus.flush && in_m;

  // ---------------- multiply datapath ----------------
  // Sign/zero-extending to 2*XLEN makes a truncated 2*XLEN product exact
  // for all three signedness combinations.
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod_in;
  logic [XLEN-1:0]   mul_res_in;

  always_comb begin
    mul_a_ext  = {{XLEN{in_sa & bus.op_a[XLEN-1]}}, bus.op_a};
    mul_b_ext  = {{XLEN{in_sb & bus.op_b[XLEN-1]}}, bus.op_b};
    prod_in    = mul_a_ext * mul_b_ext;
    mul_res_in = (bus.ALUSel == OP_MUL) ? prod_in[XLEN-1:0] : prod_in[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_SEQ_PIPE_MUL_EN
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   mul_res_pipe;
  assign mul_res_pipe = (op_reg == OP_MUL) ? prod_reg[XLEN-1:0] : prod_reg[2*XLEN-1:XLEN];
`endif

  // ---------------- divide datapath ----------------
  logic            b_zero, div_ovf, div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    b_zero      = (bus.op_b == '0);
    div_ovf     = in_sdiv && (bus.op_a == MOST_NEG) && (bus.op_b == '1);
    div_special = in_div && (b_zero || div_ovf);
    if (b_zero)
      special_res = in_rem ? bus.op_a : '1;
    else
      special_res = in_rem ? '0 : MOST_NEG;
    abs_a = (in_sdiv && bus.op_a[XLEN-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    abs_b = (in_sdiv && bus.op_b[XLEN-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract when it fits. The trial difference always fits in XLEN bits.
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] rem_step, quo_step;

  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    fits     = (shifted >= {1'b0, dvs_reg});
    rem_step = fits ? (shifted[XLEN-1:0] - dvs_reg) : shifted[XLEN-1:0];
    quo_step = {quo_reg[XLEN-2:0], fits};
  end

  logic [XLEN-1:0] fix_res;
  always_comb begin
    if ((op_reg == OP_REM) || (op_reg == OP_REMU))
      fix_res = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    else
      fix_res = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
  end

  // ---------------- control ----------------
  logic            load_res;
  logic [XLEN-1:0] res_next;

  always_comb begin
    state_next = state_reg;
    load_res   = 1'b0;
    res_next   = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (in_mul) begin
`ifdef MULDIV_SEQ_PIPE_MUL_EN
            state_next = S_MUL;
`else
            state_next = S_DONE;
            load_res   = 1'b1;
            res_next   = mul_res_in;
`endif
          end else if (div_special) begin
            state_next = S_DONE;
            load_res   = 1'b1;
            res_next   = special_res;
          end else begin
            state_next = S_DIV;
          end
        end
      end
      S_MUL: begin
`ifdef MULDIV_SEQ_PIPE_MUL_EN
        state_next = S_DONE;
        load_res   = 1'b1;
        res_next   = mul_res_pipe;
`else
        state_next = S_IDLE;
`endif
      end
      S_DIV: begin
        if (cnt_reg == LAST_IT)
          state_next = S_FIX;
      end
      S_FIX: begin
        state_next = S_DONE;
        load_res   = 1'b1;
        res_next   = fix_res;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // A flush wins over everything, including a pending result write.
    if (bus.flush) begin
      state_next = S_IDLE;
      load_res   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_res)
        result_reg <= res_next;
      if (accept) begin
        op_reg    <= bus.ALUSel;
        quo_reg   <= abs_a;
        rem_reg   <= '0;
        dvs_reg   <= abs_b;
        neg_q_reg <= in_sdiv && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
        neg_r_reg <= in_sdiv && bus.op_a[XLEN-1];
        cnt_reg   <= '0;
      end else if (bus.flush) begin
        cnt_reg <= '0;
      end else if (state_reg == S_DIV) begin
        quo_reg <= quo_step;
        rem_reg <= rem_step;
        cnt_reg <= (cnt_reg == LAST_IT) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

`ifdef MULDIV_SEQ_PIPE_MUL_EN
  always_ff @(posedge clk) begin
    if (rst)
      prod_reg <= '0;
    else if (accept)
      prod_reg <= prod_in;
  end
`endif

  // ---------------- outputs ----------------
  always_comb begin
    bus.stall  = !rst && !bus.flush &&
                 (accept || (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX));
    bus.done   = !rst && !bus.flush && (state_reg == S_DONE);
    bus.result = result_reg;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: latency, stall window and result per M-op,
// special divide cases, non-M codes, flush abort and reset abort.
module tb_muldiv_seq;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10100;
  localparam logic [4:0] OP_DIV    = 5'b10101;
  localparam logic [4:0] OP_DIVU   = 5'b10110;
  localparam logic [4:0] OP_REM    = 5'b10111;
  localparam logic [4:0] OP_REMU   = 5'b11000;

`ifdef MULDIV_SEQ_PIPE_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drives one request from posedge+1 of an IDLE cycle; returns the latency in
  // cycles from accept to the done pulse, the result, and the number of cycles
  // stall was seen high up to and including the done cycle.
  task automatic issue_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int stall_cnt);
    lat = -1;
    res = 'x;
    stall_cnt = 0;
    bus.start = 1'b1;
    bus.ALUSel = code;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    if (bus.stall === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ALUSel = 5'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stall_cnt++;
      if (bus.done === 1'b1) begin
        lat = n;
        res = bus.result;
        break;
      end
    end
    @(posedge clk); #1;
    $display("op %b a=%08h b=%08h -> result=%08h latency=%0d stall_cycles=%0d",
             code, a, b, res, lat, stall_cnt);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hold: stall=%b done=%b result=%08h, required 0/0/00000000",
               bus.stall, bus.done, bus.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release: stall=%b done=%b result=%08h, required 0/0/00000000",
               bus.stall, bus.done, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat, sc;
    logic [31:0] res;
    issue_op(code, a, b, lat, res, sc);
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    vectors++;
    if (res !== exp_res) begin
      miscompares++;
      $display("FAIL %s_result: got %08h, required %08h", name, res, exp_res);
    end
    vectors++;
    if (sc !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_stall: stall high %0d cycles, required %0d", name, sc, exp_lat);
    end
  endtask

  task automatic test_multiply();
    run_table("mul_7_m3",      OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_table("mulhu_max",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_table("mulhsu_m1_2",   OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
    run_table("mulh_min_min",  OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_table("mulh_m1_m1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
    run_table("mul_shift",     OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT);
    run_table("mulhsu_min",    OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT);
  endtask

  task automatic test_divide();
    run_table("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
    run_table("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
    run_table("div_7_m2",   OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
    run_table("rem_7_m2",   OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT);
    run_table("divu_100_7", OP_DIVU, 32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_table("remu_100_7", OP_REMU, 32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_table("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, DIV_LAT);
  endtask

  task automatic test_special();
    run_table("divu_by0",   OP_DIVU, 32'h00001234, 32'h0,        32'hFFFFFFFF, 1);
    run_table("remu_by0",   OP_REMU, 32'h00001234, 32'h0,        32'h00001234, 1);
    run_table("div_by0",    OP_DIV,  32'h00000005, 32'h0,        32'hFFFFFFFF, 1);
    run_table("rem_by0",    OP_REM,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1);
    run_table("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_table("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
  endtask

  task automatic test_non_m();
    logic [4:0] codes [3] = '{5'b00000, 5'b10011, 5'b11111};
    logic [31:0] prior;
    int bad;
    prior = 32'h00000000;  // last special case left result = 0
    foreach (codes[i]) begin
      bad = 0;
      bus.start = 1'b1;
      bus.ALUSel = codes[i];
      bus.op_a = 32'd9;
      bus.op_b = 32'd3;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== prior) bad++;
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.ALUSel = 5'b0;
      $display("non-M code %b held 5 cycles, bad cycles=%0d", codes[i], bad);
      vectors++;
      if (bad !== 0) begin
        miscompares++;
        $display("FAIL non_m_%b: %0d cycles with stall/done/result activity, required 0",
                 codes[i], bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_table("b2b_mul",  OP_MUL,  32'h00000003, 32'h00000005, 32'h0000000F, MUL_LAT);
    run_table("b2b_divu", OP_DIVU, 32'h00000F00, 32'h00000010, 32'h000000F0, DIV_LAT);
    run_table("b2b_remu", OP_REMU, 32'd1000,     32'd0,        32'd1000,     1);
  endtask

  task automatic test_flush();
    int bad;
    logic [31:0] prior;
    prior = 32'd1000;
    bad = 0;
    bus.start = 1'b1;
    bus.ALUSel = OP_DIVU;
    bus.op_a = 32'd100;
    bus.op_b = 32'd7;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.ALUSel = 5'b0;
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.stall !== 1'b1) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL flush_pre: %0d busy cycles without stall=1/done=0, required 0", bad);
    end
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle: stall=%b done=%b, required 0/0", bus.stall, bus.done);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.result !== prior || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_hold: result=%08h done=%b, required %08h/0", bus.result, bus.done, prior);
    end
    $display("flush at T+10 of DIVU 100/7, result held %08h", bus.result);
    run_table("after_flush", OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    bus.start = 1'b1;
    bus.ALUSel = OP_DIV;
    bus.op_a = 32'd100;
    bus.op_b = 32'd3;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.ALUSel = 5'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_div_during: stall=%b done=%b, required 0/0", bus.stall, bus.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_div_after: stall=%b done=%b result=%08h, required 0/0/00000000",
               bus.stall, bus.done, bus.result);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.stall !== 1'b0) pulses++;
    end
    $display("reset at T+5 of DIV 100/3, done/stall activity afterwards=%0d", pulses);
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_div_quiet: %0d cycles with done/stall, required 0", pulses);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ALUSel = 5'b0;
    bus.op_a = 32'h0;
    bus.op_b = 32'h0;
    bus.flush = 1'b0;
    test_reset();
    test_multiply();
    test_divide();
    test_special();
    test_non_m();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
